// File: rtl/bus_memory_responder.sv
// Purpose : memory-bus target for one address window. Serves single-word reads and writes from an internal word RAM and flags accesses outside the window.
// Latency : a request captured at edge N raises o_ready after edge N+1+WAIT_STATES; o_ready and o_error clear on the first edge that samples i_request low.
// Backpress: four-phase request/ready handshake. o_ready holds until i_request falls, and a new request is only accepted back in IDLE.
// Option  : BUS_MEMORY_WRITE_PROTECT_EN makes the first PROTECT_WORDS words read-only. Writes to them complete with o_error set.
module bus_memory_responder #(
    parameter int          ADDR_W        = 12,
    parameter logic [31:0] BASE          = 32'h0000_0000,
    parameter int          WAIT_STATES   = 2,
    parameter int          PROTECT_WORDS = 256
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_request,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_ready,
    output logic        o_error
);

    localparam int         TAG_LSB = ADDR_W + 2;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [3:0]          wait_cnt;
    logic                lat_rw;
    logic                lat_hit;
    logic [ADDR_W-1:0]   lat_idx;
    logic [31:0]         lat_dat;
    logic                addr_hit;
    logic                wr_blocked;
    logic                capture;
    logic                count_dn;
    logic                commit;
    logic                done_ack;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    // Bits [1:0] of the byte address do not select anything because every access is a full word.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, i_address[1:0]};

    assign addr_hit = (i_address[31:TAG_LSB] == BASE[31:TAG_LSB]);

`ifdef BUS_MEMORY_WRITE_PROTECT_EN
    localparam logic [31:0] PROT_LIMIT = 32'(PROTECT_WORDS);
    assign wr_blocked = lat_rw && lat_hit && (32'(lat_idx) < PROT_LIMIT);
`else
    localparam int unused_protect_words = PROTECT_WORDS;
    assign wr_blocked = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clock) begin
        if (i_reset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic and the one-cycle strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        count_dn  = 1'b0;
        commit    = 1'b0;
        done_ack  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_request) begin
                    capture   = 1'b1;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!i_request) begin
                    // The initiator withdrew the request, so the access is dropped without touching RAM or outputs.
                    state_nxt = S_IDLE;
                end else if (wait_cnt != 4'd0) begin
                    count_dn = 1'b1;
                end else begin
                    commit    = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (!i_request) begin
                    done_ack  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Latch the request, run the wait counter, and drive the response outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wait_cnt <= 4'd0;
            lat_rw   <= 1'b0;
            lat_hit  <= 1'b0;
            lat_idx  <= '0;
            lat_dat  <= 32'd0;
            o_data   <= 32'd0;
            o_ready  <= 1'b0;
            o_error  <= 1'b0;
        end else begin
            if (capture) begin
                lat_rw   <= i_rw;
                lat_hit  <= addr_hit;
                lat_idx  <= i_address[TAG_LSB-1:2];
                lat_dat  <= i_data;
                wait_cnt <= WS_LOAD;
            end
            if (count_dn) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit) begin
                o_ready <= 1'b1;
                o_error <= !lat_hit || wr_blocked;
                // o_data changes only on reads. Writes leave the last read value in place.
                if (!lat_rw) begin
                    o_data <= lat_hit ? mem[lat_idx] : 32'd0;
                end
            end
            if (done_ack) begin
                o_ready <= 1'b0;
                o_error <= 1'b0;
            end
        end
    end

    // RAM write port. Contents survive reset, but a reset on the commit edge cancels the write.
    always_ff @(posedge i_clock) begin
        if (!i_reset && commit && lat_rw && lat_hit && !wr_blocked) begin
            mem[lat_idx] <= lat_dat;
        end
    end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- Target-side end of the CPU memory bus: accepts single-word read/write requests (request/ready four-phase handshake), services them from an internal word RAM after a programmable number of wait states, and returns read data.
- Sits between the bus initiator and the address decode; one instance per memory region (boot RAM, stack RAM).
- Reports accesses outside its window, and protected-region writes, through an error flag.

Parameters:
- ADDR_W, 12, word-address width; RAM depth = 2**ADDR_W 32-bit words.
- BASE, 32'h0000_0000, byte base address of the window; must be aligned to 4*2**ADDR_W.
- WAIT_STATES, 2, extra cycles between request capture and ready (0..15).
- PROTECT_WORDS, 256, number of words from BASE that are read-only when the optional feature is compiled in.

Ports:
- i_clock  in  1  clock; all logic on posedge.
- i_reset  in  1  synchronous, active-high reset.
- i_request  in  1  access request from initiator; held high until o_ready is seen.
- i_rw  in  1  0 = read, 1 = write; valid while i_request is high.
- i_address  in  32  byte address; bits [1:0] ignored (word access only).
- i_data  in  32  write data; valid while i_request is high.
- o_data  out  32  read data; valid while o_ready is high.
- o_ready  out  1  access complete; held until i_request falls.
- o_error  out  1  qualifies o_ready: out-of-window or protected-write access.

Behaviour:
- Reset: state IDLE, o_ready=0, o_error=0, o_data=0, wait counter=0. RAM contents are not cleared. Reset mid-access abandons the access; any write not yet committed is lost.
- Window hit: i_address[31:ADDR_W+2] == BASE[31:ADDR_W+2]. Word index = i_address[ADDR_W+1:2].
- State IDLE:
  - On an edge with i_request=1, latch rw, word index, hit flag and write data.
  - Load counter = WAIT_STATES; go to WAIT.
- State WAIT:
  - If i_request=0 (initiator abort): go to IDLE; no RAM write, outputs unchanged.
  - Else if counter != 0: decrement.
  - Else (counter == 0), commit the access, set o_ready<=1, go to ACK:
    - hit read: o_data <= RAM[index].
    - hit write: RAM[index] <= latched data.
    - miss read: o_data <= 0, o_error <= 1.
    - miss write: discarded, o_error <= 1.
- State ACK:
  - Hold o_ready, o_error and o_data while i_request=1.
  - On the first edge with i_request=0: o_ready<=0, o_error<=0, go to IDLE. o_data holds its last read value.
- Latency: request sampled at edge N gives o_ready high after edge N+1+WAIT_STATES. A new request is accepted no earlier than the edge after o_ready falls.
- Back-to-back: the initiator cannot re-raise i_request before this block has seen it low, because ACK requires a low sample. This enforces the four-phase protocol.
- Write data and address are captured once in IDLE. Changes on i_address or i_data during WAIT or ACK are ignored.
- o_data changes only on completed reads; writes leave it untouched.
- Index wrap is impossible: the index is exactly ADDR_W bits.

Optional Feature:
- Macro: BUS_MEMORY_WRITE_PROTECT_EN.
- Defined:
  - Hit writes with index < PROTECT_WORDS are acknowledged with o_error=1 and the RAM is unchanged.
  - Reads of that region are normal.
- Undefined: every in-window word is writable and PROTECT_WORDS is unused.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to 0x0000_0800 and read it back (WAIT_STATES=2, feature off) -> o_ready rises on the 3rd edge after request capture; read returns 32'hDEAD_BEEF; o_error=0.
- Read 0x0001_0000 (outside a 16 KiB window at BASE 0) -> o_ready=1, o_error=1, o_data=0; both flags clear the edge after i_request falls.
- Raise i_request for a write to 0x0000_0010 with 32'h1234_5678, drop it after 1 cycle (before ready) -> no o_ready; a later read of 0x0000_0010 returns the prior contents.
- Hold i_request high for 5 cycles after o_ready -> o_ready and o_data stay stable throughout. Re-raise i_request the cycle after the falling sample -> second access completes normally.
- Assert i_reset during WAIT of a write to 0x0000_0020 -> outputs reach reset values the next edge; the word is not modified.
- With BUS_MEMORY_WRITE_PROTECT_EN defined and PROTECT_WORDS=256, write 32'hFFFF_FFFF to 0x0000_0004 -> o_error=1, read-back unchanged. A write to 0x0000_0400 succeeds with o_error=0.
